// File: rtl/sphere_hit_pkg.sv
// Shared types and fixed-point helpers for the sequential sphere-hit engine.
// Helpers work on SH_PROD_W-bit signed operands; callers sign-extend W-bit
// values (W <= SH_W) and truncate the result back to W bits, which gives
// wrap-around on overflow.
package sphere_hit_pkg;

  localparam int SH_W       = 32;
  localparam int SH_PROD_W  = 2 * SH_W;
  localparam int SH_STATE_W = 3;

  typedef enum logic [SH_STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DOT   = 3'd2,
    ST_DISC  = 3'd3,
    ST_SQRT  = 3'd4,
    ST_CMP   = 3'd5,
    ST_NEXT  = 3'd6,
    ST_DONE  = 3'd7
  } sphere_hit_state_e;

  // Full-width product, arithmetic-shifted back to the operand's Q format.
  function automatic logic signed [SH_PROD_W-1:0] fx_mul(
    input logic signed [SH_PROD_W-1:0] a,
    input logic signed [SH_PROD_W-1:0] b,
    input int unsigned                 frac
  );
    logic signed [SH_PROD_W-1:0] p;
    p = a * b;
    return p >>> frac;
  endfunction

  function automatic logic signed [SH_PROD_W-1:0] fx_dot3(
    input logic signed [SH_PROD_W-1:0] ax,
    input logic signed [SH_PROD_W-1:0] ay,
    input logic signed [SH_PROD_W-1:0] az,
    input logic signed [SH_PROD_W-1:0] bx,
    input logic signed [SH_PROD_W-1:0] by,
    input logic signed [SH_PROD_W-1:0] bz,
    input int unsigned                 frac
  );
    return fx_mul(ax, bx, frac) + fx_mul(ay, by, frac) + fx_mul(az, bz, frac);
  endfunction

endpackage

// File: rtl/fixed_isqrt_iter.sv
// Restoring integer square root: 2W-bit radicand, W-bit root, one root bit
// per clock. A start pulse loads the operand; done is high during the final
// iteration cycle, so root is valid from the following cycle on.
module fixed_isqrt_iter #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*W-1:0] radicand,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   root
);

  localparam int REM_W = W + 4;
  localparam int CNT_W = $clog2(W + 1);

  logic [2*W-1:0]   rad_q;
  logic [REM_W-1:0] rem_q;
  logic [W-1:0]     root_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  logic [REM_W-1:0] rem_sh;
  logic [REM_W-1:0] trial;
  logic             fits;

  // One restoring step: bring down two radicand bits, try root*4+1.
  always_comb begin
    rem_sh = {rem_q[REM_W-3:0], rad_q[2*W-1 -: 2]};
    trial  = {{(REM_W-W-2){1'b0}}, root_q, 2'b01};
    fits   = (rem_sh >= trial);
  end

  // Iteration registers; start overrides an iteration in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rad_q  <= radicand;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= CNT_W'(W);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rad_q  <= rad_q << 2;
      rem_q  <= fits ? (rem_sh - trial) : rem_sh;
      root_q <= {root_q[W-2:0], fits};
      cnt_q  <= cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CNT_W'(1));
  assign root = root_q;

endmodule

// File: rtl/sphere_hit_seq.sv
// Sequential closest-hit engine: one ray per handshake, walks the sphere
// table one entry at a time and reports the nearest root in (T_EPS, t_max).
// Optional build macro SPHERE_HIT_EARLY_OUT_EN: any-hit mode, the first
// accepted root ends the scan. W must not exceed sphere_hit_pkg::SH_W.
//
// state | meaning
// IDLE  | waiting for a ray, in_ready high
// FETCH | sphere address on sph_rd_idx
// DOT   | table data arrives, register b and c
// DISC  | discriminant sign test, launch sqrt
// SQRT  | W cycles of root iteration
// CMP   | pick root, keep nearest
// NEXT  | advance index or finish
// DONE  | result held until out_ready
module sphere_hit_seq
  import sphere_hit_pkg::*;
#(
  parameter int W           = SH_W,
  parameter int FRAC_BITS   = 16,
  parameter int NUM_SPHERES = 8,
  parameter int IDX_W       = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1,
  parameter int T_EPS       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3*W-1:0]   ray_orig,
  input  logic [3*W-1:0]   ray_dir,
  input  logic [W-1:0]     t_max,
  output logic [IDX_W-1:0] sph_rd_idx,
  input  logic [3*W-1:0]   sph_center,
  input  logic [W-1:0]     sph_radius2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_hit,
  output logic [W-1:0]     out_t,
  output logic [IDX_W-1:0] out_index
);

  localparam int PW = 2 * W;
  localparam logic signed [W-1:0] T_EPS_W = W'(T_EPS);

  sphere_hit_state_e state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, best_idx_q, best_idx_d;
  logic [3*W-1:0]    orig_q, orig_d, dir_q, dir_d;
  logic signed [W-1:0] best_t_q, best_t_d, b_q, b_d, c_q, c_d;
  logic              hit_q, hit_d;

  logic signed [W-1:0]  oc_x, oc_y, oc_z, d_x, d_y, d_z;
  logic signed [W-1:0]  b_dot, c_dot;
  logic signed [PW-1:0] b_e, c_e, disc;
  logic signed [W-1:0]  s, t0, t1, t_sel;
  logic                 t0_ok, t1_ok, closer;

  logic         sq_start, sq_busy, sq_done;
  logic [W-1:0] sq_root;

  fixed_isqrt_iter #(.W(W)) u_isqrt (
    .clk      (clk),
    .reset    (reset),
    .start    (sq_start),
    .radicand (disc),
    .busy     (sq_busy),
    .done     (sq_done),
    .root     (sq_root)
  );

  // Per-sphere datapath: dot products, discriminant and root selection.
  always_comb begin
    oc_x  = orig_q[W-1:0]     - sph_center[W-1:0];
    oc_y  = orig_q[2*W-1:W]   - sph_center[2*W-1:W];
    oc_z  = orig_q[3*W-1:2*W] - sph_center[3*W-1:2*W];
    d_x   = dir_q[W-1:0];
    d_y   = dir_q[2*W-1:W];
    d_z   = dir_q[3*W-1:2*W];
    b_dot = W'(fx_dot3(SH_PROD_W'(oc_x), SH_PROD_W'(oc_y), SH_PROD_W'(oc_z),
                       SH_PROD_W'(d_x), SH_PROD_W'(d_y), SH_PROD_W'(d_z), FRAC_BITS));
    c_dot = W'(fx_dot3(SH_PROD_W'(oc_x), SH_PROD_W'(oc_y), SH_PROD_W'(oc_z),
                       SH_PROD_W'(oc_x), SH_PROD_W'(oc_y), SH_PROD_W'(oc_z), FRAC_BITS))
            - signed'(sph_radius2);
    b_e    = PW'(b_q);
    c_e    = PW'(c_q);
    disc   = b_e * b_e - (c_e <<< FRAC_BITS);
    s      = signed'(sq_root);
    t0     = -b_q - s;
    t1     = -b_q + s;
    t0_ok  = (t0 > T_EPS_W);
    t1_ok  = (t1 > T_EPS_W);
    t_sel  = t0_ok ? t0 : t1;
    closer = (t0_ok || t1_ok) && (t_sel < best_t_q);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      best_idx_q <= '0;
      orig_q     <= '0;
      dir_q      <= '0;
      best_t_q   <= '0;
      b_q        <= '0;
      c_q        <= '0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      orig_q     <= orig_d;
      dir_q      <= dir_d;
      best_t_q   <= best_t_d;
      b_q        <= b_d;
      c_q        <= c_d;
      hit_q      <= hit_d;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    orig_d     = orig_q;
    dir_d      = dir_q;
    best_t_d   = best_t_q;
    b_d        = b_q;
    c_d        = c_q;
    hit_d      = hit_q;
    sq_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          orig_d     = ray_orig;
          dir_d      = ray_dir;
          best_t_d   = signed'(t_max);
          best_idx_d = '0;
          hit_d      = 1'b0;
          idx_d      = '0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_DOT;
      ST_DOT: begin
        b_d     = b_dot;
        c_d     = c_dot;
        state_d = ST_DISC;
      end
      ST_DISC: begin
        if (disc[PW-1]) begin
          state_d = ST_NEXT;
        end else begin
          sq_start = 1'b1;
          state_d  = ST_SQRT;
        end
      end
      // done only qualifies while a root is actually in flight
      ST_SQRT: if (sq_busy && sq_done) state_d = ST_CMP;
      ST_CMP: begin
        state_d = ST_NEXT;
        if (closer) begin
          best_t_d   = t_sel;
          best_idx_d = idx_q;
          hit_d      = 1'b1;
`ifdef SPHERE_HIT_EARLY_OUT_EN
          state_d    = ST_DONE;
`else
          state_d    = ST_NEXT;
`endif
        end
      end
      ST_NEXT: begin
        if (idx_q == IDX_W'(NUM_SPHERES - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready   = (state_q == ST_IDLE) && !reset;
  assign out_valid  = (state_q == ST_DONE);
  assign out_hit    = hit_q;
  assign out_t      = best_t_q;
  assign out_index  = best_idx_q;
  assign sph_rd_idx = idx_q;

endmodule

// File: tb/tb_sphere_hit_seq.sv
// Directed bench for sphere_hit_seq with a two-entry sphere table.
module tb_sphere_hit_seq;

`ifdef SPHERE_HIT_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic         clk, reset, in_valid, in_ready, out_valid, out_ready, out_hit;
  logic [95:0]  ray_orig, ray_dir, sph_center;
  logic [31:0]  t_max, sph_radius2, out_t;
  logic         sph_rd_idx, out_index;

  logic [95:0]  ctab [2];
  logic [31:0]  rtab [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] c0z, c0y, r0, c1z, c1y, r1, oz, tmax;
    logic        hit;
    logic [31:0] t;
    logic        idx;
    int          lat;
  } vec_t;

  vec_t vecs [7];

  sphere_hit_seq #(
    .W(32), .FRAC_BITS(16), .NUM_SPHERES(2), .IDX_W(1), .T_EPS(1)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ray_orig(ray_orig), .ray_dir(ray_dir), .t_max(t_max),
    .sph_rd_idx(sph_rd_idx), .sph_center(sph_center), .sph_radius2(sph_radius2),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_t(out_t), .out_index(out_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous sphere table, data one cycle after the address
  always @(posedge clk) begin
    sph_center  <= ctab[sph_rd_idx];
    sph_radius2 <= rtab[sph_rd_idx];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    ctab[0] = {v.c0z, v.c0y, 32'h0};
    rtab[0] = v.r0;
    ctab[1] = {v.c1z, v.c1y, 32'h0};
    rtab[1] = v.r1;
  endtask

  task automatic send(input vec_t v);
    int guard;
    load(v);
    @(negedge clk);
    ray_orig = {v.oz, 64'h0};
    ray_dir  = {32'h0001_0000, 64'h0};
    t_max    = v.tmax;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", in_ready, 1);
  endtask

  // Send one ray, measure latency, check the result, hold out_ready low for
  // 'hold' cycles, then complete the output handshake.
  task automatic run_ray(input vec_t v, input int hold, input string tag);
    int lat;
    send(v);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 500) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_hit"}, out_hit, v.hit);
    check({tag, "_t"}, out_t, v.t);
    check({tag, "_idx"}, out_index, v.idx);
    check({tag, "_lat"}, lat, v.lat);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_t"}, out_t, v.t);
      check({tag, "_hold_idx"}, out_index, v.idx);
      check({tag, "_hold_inrdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_valid"}, out_valid, 0);
    check({tag, "_post_inrdy"}, in_ready, 1);
  endtask

  initial begin
    //          c0z          c0y          r0           c1z          c1y          r1           oz           tmax         hit  t            idx lat
    vecs[0] = '{32'h50000, 32'h0,     32'h10000, 32'h0,     32'h50000, 32'h0,     32'h0,     32'h7FFF0000, 1'b1, 32'h40000, 1'b0, EO ? 37 : 42};
    vecs[1] = '{32'h50000, 32'h0,     32'h10000, 32'h30000, 32'h0,     32'h10000, 32'h0,     32'h7FFF0000, 1'b1,
                EO ? 32'h40000 : 32'h20000, EO ? 1'b0 : 1'b1, EO ? 37 : 75};
    vecs[2] = '{32'h30000, 32'h0,     32'h10000, 32'h30000, 32'h0,     32'h10000, 32'h0,     32'h7FFF0000, 1'b1, 32'h20000, 1'b0, EO ? 37 : 75};
    vecs[3] = '{32'h0,     32'h50000, 32'h10000, 32'h0,     32'h50000, 32'h10000, 32'h0,     32'h7FFF0000, 1'b0, 32'h7FFF0000, 1'b0, 9};
    vecs[4] = '{32'h0,     32'h0,     32'h40000, 32'h0,     32'h50000, 32'h0,     32'h0,     32'h7FFF0000, 1'b1, 32'h20000, 1'b0, EO ? 37 : 42};
    vecs[5] = '{32'h50000, 32'h0,     32'h10000, 32'h0,     32'h50000, 32'h0,     32'h0,     32'h30000,    1'b0, 32'h30000, 1'b0, 42};
    vecs[6] = '{32'h50000, 32'h0,     32'h10000, 32'h0,     32'h50000, 32'h0,     32'hA0000, 32'h7FFF0000, 1'b0, 32'h7FFF0000, 1'b0, 42};

    ctab[0] = '0; ctab[1] = '0; rtab[0] = '0; rtab[1] = '0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ray_orig = '0; ray_dir = '0; t_max = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_hit", out_hit, 0);
    check("rst_out_t", out_t, 0);
    check("rst_out_index", out_index, 0);
    check("rst_rd_idx", sph_rd_idx, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_release_in_ready", in_ready, 1);

    for (int i = 0; i < 7; i++) begin
      run_ray(vecs[i], 0, $sformatf("v%0d", i));
    end

    run_ray(vecs[0], 10, "stall");

    // reset while the square root is iterating
    send(vecs[1]);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_rd_idx", sph_rd_idx, 0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_idle", in_ready, 1);
    check("midrst_out_valid2", out_valid, 0);
    run_ray(vecs[1], 0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
